// File: rtl/fwd_scoreboard.sv
// Forwarding/load-use hazard unit with a shift-register destination scoreboard.
// Optional saturating stall counter enabled by defining FWD_STALL_CNT_EN.
module fwd_scoreboard #(
  parameter  int ADDR_W     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STALL = 1,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic                      issue_regwrite,
  input  logic                      issue_memread,
  input  logic [ADDR_W-1:0]         issue_waddr,
  input  logic [NUM_SRC*ADDR_W-1:0] issue_src,
  input  logic                      flush,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              load;
    logic [ADDR_W-1:0] waddr;
  } slot_t;

  slot_t                     slot_q [DEPTH];
  slot_t                     issue_e;
  logic                      go;
  logic                      hazard;
  logic                      found;
  logic [ADDR_W-1:0]         src;
  logic [NUM_SRC*SEL_W-1:0]  sel_d;

  assign issue_e = '{1'b1, issue_regwrite, issue_memread, issue_waddr};

  // Youngest matching slot wins; the last slot is already written back.
  always_comb begin
    sel_d  = '0;
    hazard = 1'b0;
    found  = 1'b0;
    src    = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      src   = issue_src[j*ADDR_W +: ADDR_W];
      found = 1'b0;
      for (int k = 0; k < DEPTH-1; k++) begin
        if (!found && slot_q[k].valid && slot_q[k].regwrite &&
            slot_q[k].waddr != '0 && slot_q[k].waddr == src) begin
          found = 1'b1;
          sel_d[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
          if (slot_q[k].load && k < LOAD_STALL)
            hazard = 1'b1;
        end
      end
    end
  end

  assign stall = issue_valid && !flush && hazard;
  assign go    = issue_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++)
        slot_q[k] <= '0;
      ex_valid <= 1'b0;
      fwd_sel  <= '0;
    end else begin
      slot_q[0] <= go ? issue_e : '0;
      for (int k = 1; k < DEPTH; k++)
        slot_q[k] <= slot_q[k-1];
      // flush also kills the instruction leaving slot 0
      if (flush)
        slot_q[1] <= '0;
      ex_valid <= go;
      fwd_sel  <= go ? sel_d : '0;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default build and DEPTH=4/LOAD_STALL=2.
// Counter checks are active when FWD_STALL_CNT_EN is defined.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_vld, a_rw, a_ld, a_flush;
  logic [4:0]  a_wa;
  logic [9:0]  a_src;
  logic        a_stall, a_exv;
  logic [3:0]  a_sel;
  logic        b_vld, b_rw, b_ld, b_flush;
  logic [4:0]  b_wa;
  logic [9:0]  b_src;
  logic        b_stall, b_exv;
  logic [3:0]  b_sel;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_scoreboard u_a (
    .clk(clk), .reset(reset),
    .issue_valid(a_vld), .issue_regwrite(a_rw),
    .issue_memread(a_ld), .issue_waddr(a_wa),
    .issue_src(a_src), .flush(a_flush),
    .stall(a_stall), .ex_valid(a_exv), .fwd_sel(a_sel)
`ifdef FWD_STALL_CNT_EN
    , .stall_count(a_cnt)
`endif
  );

  fwd_scoreboard #(.DEPTH(4), .LOAD_STALL(2)) u_b (
    .clk(clk), .reset(reset),
    .issue_valid(b_vld), .issue_regwrite(b_rw),
    .issue_memread(b_ld), .issue_waddr(b_wa),
    .issue_src(b_src), .flush(b_flush),
    .stall(b_stall), .ex_valid(b_exv), .fwd_sel(b_sel)
`ifdef FWD_STALL_CNT_EN
    , .stall_count(b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic rw, input logic ld,
                         input logic [4:0] wa,
                         input logic [4:0] s0, input logic [4:0] s1);
    a_vld = 1'b1; a_rw = rw; a_ld = ld; a_wa = wa;
    a_src = {s1, s0};
    #1;
  endtask

  task automatic b_issue(input logic ld, input logic [4:0] wa,
                         input logic [4:0] s0, input logic [4:0] s1);
    b_vld = 1'b1; b_rw = 1'b1; b_ld = ld; b_wa = wa;
    b_src = {s1, s0};
    #1;
  endtask

  initial begin
    reset = 1'b1; a_flush = 1'b0; b_flush = 1'b0;
    a_vld = 1'b1; a_rw = 1'b1; a_ld = 1'b1; a_wa = 5'd8;
    a_src = {5'd8, 5'd8};
    b_vld = 1'b0; b_rw = 1'b0; b_ld = 1'b0; b_wa = '0; b_src = '0;
    tick; tick;
    chk("rst_exv", a_exv, 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_stall", a_stall, 0);
`ifdef FWD_STALL_CNT_EN
    chk("rst_cnt", a_cnt, 0);
`endif
    reset = 1'b0;

    // ALU chain
    a_issue(1, 0, 8, 1, 2);
    chk("alu1_stall", a_stall, 0);
    tick;
    chk("alu1_exv", a_exv, 1);
    chk("alu1_sel", a_sel, 4'b0000);
    a_issue(1, 0, 9, 8, 8);
    tick;
    chk("alu2_sel", a_sel, 4'b0101);
    a_issue(1, 0, 10, 8, 0);
    tick;
    chk("alu3_sel", a_sel, 4'b0010);
    a_issue(1, 0, 11, 8, 9);
    tick;
    chk("alu4_sel", a_sel, 4'b1000);

    // load-use
    a_issue(1, 1, 12, 1, 0);
    tick;
    a_issue(1, 0, 13, 12, 3);
    chk("lu_stall1", a_stall, 1);
    tick;
    chk("lu_bub_exv", a_exv, 0);
    chk("lu_bub_sel", a_sel, 0);
    chk("lu_stall2", a_stall, 0);
    tick;
    chk("lu_exv", a_exv, 1);
    chk("lu_sel", a_sel, 4'b0010);
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt", a_cnt, 1);
`endif

    // younger ALU write masks older load
    a_issue(1, 1, 8, 0, 0);
    tick;
    a_issue(1, 0, 8, 4, 0);
    tick;
    a_issue(1, 0, 20, 8, 8);
    chk("pri_stall", a_stall, 0);
    tick;
    chk("pri_sel", a_sel, 4'b0101);

    // flush kills consumer and slot-0 load
    a_issue(1, 1, 14, 0, 0);
    tick;
    a_issue(1, 0, 21, 14, 0);
    a_flush = 1'b1;
    #1;
    chk("fl_stall", a_stall, 0);
    tick;
    a_flush = 1'b0;
    chk("fl_exv", a_exv, 0);
    chk("fl_sel", a_sel, 0);
    a_issue(1, 0, 21, 14, 0);
    chk("fl_stall2", a_stall, 0);
    tick;
    chk("fl2_exv", a_exv, 1);
    chk("fl2_sel", a_sel, 0);

    // issue_valid low suppresses stall
    a_issue(1, 1, 15, 0, 0);
    tick;
    a_issue(1, 0, 22, 15, 0);
    a_vld = 1'b0;
    #1;
    chk("nv_stall", a_stall, 0);
    tick;
    chk("nv_exv", a_exv, 0);
    a_issue(1, 0, 22, 15, 0);
    chk("nv_stall2", a_stall, 0);
    tick;
    chk("nv_sel", a_sel, 4'b0010);

    // reset during a stall
    a_issue(1, 1, 16, 0, 0);
    tick;
    a_issue(1, 0, 23, 16, 0);
    chk("rs_stall", a_stall, 1);
    reset = 1'b1;
    tick;
    chk("rs_stall2", a_stall, 0);
    chk("rs_exv", a_exv, 0);
`ifdef FWD_STALL_CNT_EN
    chk("rs_cnt", a_cnt, 0);
`endif
    reset = 1'b0;
    a_vld = 1'b0;

    // DEPTH=4, LOAD_STALL=2
    b_issue(1, 5, 0, 0);
    tick;
    b_issue(0, 6, 1, 0);
    chk("b_unrel_stall", b_stall, 0);
    tick;
    b_issue(0, 7, 0, 5);
    chk("b_stall1", b_stall, 1);
    tick;
    chk("b_bub_exv", b_exv, 0);
    chk("b_stall2", b_stall, 0);
    tick;
    chk("b_exv", b_exv, 1);
    chk("b_sel", b_sel, 4'b1100);
`ifdef FWD_STALL_CNT_EN
    chk("b_cnt", b_cnt, 1);
`endif
    b_issue(0, 9, 0, 5);
    tick;
    chk("b_old_sel", b_sel, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
